inst_queue: RTL and testbench
=============================

# inst_queue

Instruction queue between the instruction fetcher and the dispatcher. It buffers decoded instructions (raw instruction, PC, optype, prediction bit) and presents the head entry to the dispatcher only when the entry's destination unit can accept it. A ROB flush empties it. Every asserted `ifetch_valid` therefore corresponds to exactly one guaranteed issue.

## Interface
- `DEPTH`, default 8: number of entries; must be a power of two, ≥2.
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `rdy` input 1: global enable; when low, state freezes.
- `in_valid` input 1: fetcher presents an instruction.
- `in_inst` input 32: raw instruction.
- `in_pc` input 32: instruction PC.
- `in_optype` input 6: decoded optype.
- `in_pred_jump` input 1: branch predicted taken.
- `in_ready` output 1: queue accepts a push this cycle.
- `flush` input 1: ROB misprediction clear.
- `ROB_full`, `RS_full`, `LSB_full` input 1 each: downstream full flags.
- `ifetch_valid` output 1: head issues this cycle.
- `ifetch_inst` output 32, `ifetch_pc` output 32, `ifetch_optype` output 6, `ifetch_pred_jump` output 1: head fields.

## Operation
- Storage is a circular buffer with `head`, `tail` (log2(DEPTH) bits, wrap modulo DEPTH) and `count` (log2(DEPTH)+1 bits).
- Push: `rdy && in_valid && in_ready && !flush` writes to `tail` and advances `tail`.
- `in_ready = (count != DEPTH)`. This is registered state only and does not depend on same-cycle pop, so no combinational path from downstream flags to the fetcher.
- A head entry is load/store when `` `LB <= optype <= `SW ``.
- Issue condition: `count != 0 && !ROB_full && (ls ? !LSB_full : !RS_full)`.
- `ifetch_valid = rdy && !rst && !flush && issue condition`. A pop advances `head` whenever `ifetch_valid` is asserted.
- `ifetch_*` data is driven combinationally from `entry[head]`. When `ifetch_valid` is 0, the data outputs are 0.
- Simultaneous push and pop: `count` is unchanged; both pointers advance.
- Flush: `head`, `tail` and `count` return to 0 next cycle; a same-cycle push is discarded; `ifetch_valid` is 0 in the flush cycle.
- `rdy` low: no push, no pop, `ifetch_valid` = 0, all state held.
- Head-of-line blocking: a blocked head stalls younger entries, which preserves program order.

## Timing
- Reset values: `head`, `tail` and `count` are 0, `in_ready` is 1, `ifetch_valid` is 0, data outputs are 0. Entry contents are don't-care.
- Reset asserted mid-operation discards all entries at the next edge.
- Push-to-issue latency: 1 cycle minimum. An entry written at edge N can issue in cycle N+1.
- `ifetch_valid` responds combinationally to the `ROB_full`, `RS_full` and `LSB_full` levels in the same cycle.
- Full: an in-flight push is refused even if a pop occurs the same cycle. The slot frees one cycle after the pop.

## Configuration
- `IQ_BYPASS_EN` defined:
  - When `count == 0`, `in_valid` is high and the input optype's unit is not full, the input is presented directly on `ifetch_*` with `ifetch_valid` = 1, and nothing is written.
  - Latency is 0 cycles.
  - Flush and `rdy` rules still apply.
- `IQ_BYPASS_EN` undefined: no bypass; minimum latency is 1 cycle.

## Structure
- Shared defines file: `` `LB ``, `` `SW ``, `` `True ``, `` `False ``, optype width, and a new `` `IQRange `` for pointer width.
- One sub-module, `iq_ram`: a DEPTH×71-bit storage array with a synchronous write port and an asynchronous read port.
- Pointers, count, issue gating and bypass logic live in `inst_queue`.

## Test plan
- **Reset:** `rst`=1 for 2 cycles, then 0 → `in_ready`=1, `ifetch_valid`=0, all outputs 0.
- **Single issue:** push ADD at pc=0x100 with all full flags low → `ifetch_valid`=1 the next cycle with `ifetch_pc`=0x100; `count` returns to 0.
- **Load/store routing:** push LW then ADD with `LSB_full`=1 and `RS_full`=0 → no issue while `LSB_full`=1. Drop `LSB_full` → LW issues, then ADD issues the following cycle.
- **Fill and wrap:** 8 pushes with `ROB_full`=1 → `in_ready`=0 and the 9th push is ignored. Release `ROB_full` and push 8 more → 16 issues in push order with PCs intact across pointer wrap.
- **Flush:** queue holds 5 entries, assert `flush` together with a push → `ifetch_valid`=0 that cycle, `count`=0 next cycle, and the pushed entry never issues.
- **Bypass / rdy:** with `IQ_BYPASS_EN`, empty queue and `in_valid` → `ifetch_valid`=1 in the same cycle. With `rdy`=0 held 3 cycles → pointers unchanged and `ifetch_valid`=0.

Source files
------------

// File: rtl/inst_queue_pkg.sv
// inst_queue_pkg: shared defines, entry layout and unit-routing helpers for the instruction queue.
`ifndef INST_QUEUE_DEFINES
`define INST_QUEUE_DEFINES
`define True 1'b1
`define False 1'b0
`define OpTypeWidth 6
`define LB 6'd11
`define SW 6'd18
`define IQRange 2:0
`endif

package inst_queue_pkg;
    localparam int OPW = `OpTypeWidth;
    localparam logic [OPW-1:0] OP_LB = `LB;
    localparam logic [OPW-1:0] OP_LW = 6'd13;
    localparam logic [OPW-1:0] OP_SW = `SW;
    localparam logic [OPW-1:0] OP_ADD = 6'd26;

    typedef struct packed {
        logic [31:0]    inst;
        logic [31:0]    pc;
        logic [OPW-1:0] optype;
        logic           pred_jump;
    } entry_t;

    function automatic logic is_ls(input logic [OPW-1:0] op);
        return op >= OP_LB && op <= OP_SW;
    endfunction

    // Loads/stores go to the LSB, everything else to the RS; all need a ROB slot.
    function automatic logic unit_free(input logic [OPW-1:0] op, input logic rob, input logic rs, input logic lsb);
        return !rob && (is_ls(op) ? !lsb : !rs);
    endfunction
endpackage

// File: rtl/inst_queue_if.sv
// inst_queue_if: fetcher push channel and dispatcher issue channel of the instruction queue.
interface inst_queue_if;
    import inst_queue_pkg::*;
    logic           in_valid;
    logic [31:0]    in_inst;
    logic [31:0]    in_pc;
    logic [OPW-1:0] in_optype;
    logic           in_pred_jump;
    logic           in_ready;
    logic           ifetch_valid;
    logic [31:0]    ifetch_inst;
    logic [31:0]    ifetch_pc;
    logic [OPW-1:0] ifetch_optype;
    logic           ifetch_pred_jump;
    modport master (
        output in_valid, in_inst, in_pc, in_optype, in_pred_jump,
        input  in_ready, ifetch_valid, ifetch_inst, ifetch_pc, ifetch_optype, ifetch_pred_jump
    );
    modport slave (
        input  in_valid, in_inst, in_pc, in_optype, in_pred_jump,
        output in_ready, ifetch_valid, ifetch_inst, ifetch_pc, ifetch_optype, ifetch_pred_jump
    );
endinterface

// File: rtl/inst_queue_iq_ram.sv
// iq_ram: DEPTH-entry instruction storage, synchronous write and asynchronous read.
module iq_ram
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  entry_t                   wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output entry_t                   rdata
);
    entry_t mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/inst_queue.sv
// inst_queue: in-order instruction buffer between fetcher and dispatcher.
// Define IQ_BYPASS_EN to forward an instruction straight through when the queue is empty.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush,
    input  logic        ROB_full,
    input  logic        RS_full,
    input  logic        LSB_full,
    inst_queue_if.slave iq
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [AW-1:0] head, tail;
    logic [AW:0]   count;
    entry_t        in_entry, head_entry, out_entry;
    logic          empty, bypass, fire, push, pop;

    assign in_entry = '{inst: iq.in_inst, pc: iq.in_pc, optype: iq.in_optype, pred_jump: iq.in_pred_jump};
    assign empty = count == '0;
    // Registered-only: no combinational path from downstream full flags back to the fetcher.
    assign iq.in_ready = count != FULL;
`ifdef IQ_BYPASS_EN
    assign bypass = empty && iq.in_valid && unit_free(iq.in_optype, ROB_full, RS_full, LSB_full);
`else
    assign bypass = 1'b0;
`endif
    assign fire = rdy && !rst && !flush && (empty ? bypass : unit_free(head_entry.optype, ROB_full, RS_full, LSB_full));
    assign pop = fire && !empty;
    assign push = rdy && !flush && iq.in_valid && iq.in_ready && !(fire && empty);

    assign out_entry = fire ? (empty ? in_entry : head_entry) : '0;
    assign iq.ifetch_valid = fire;
    assign iq.ifetch_inst = out_entry.inst;
    assign iq.ifetch_pc = out_entry.pc;
    assign iq.ifetch_optype = out_entry.optype;
    assign iq.ifetch_pred_jump = out_entry.pred_jump;

    iq_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (tail),
        .wdata (in_entry),
        .raddr (head),
        .rdata (head_entry)
    );

    always_ff @(posedge clk)
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy) begin
            head  <= head + AW'(pop);
            tail  <= tail + AW'(push);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: randomized and directed bench for inst_queue against a queue-based reference model.
module tb_inst_queue;
    import inst_queue_pkg::*;
    localparam int DEPTH = 8;
`ifdef IQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1, rdy = 1'b1, flush = 1'b0;
    logic rob = 1'b0, rs = 1'b0, lsb = 1'b0;
    bit   chk_en = 1'b0;
    int   n_vec = 0, n_err = 0;
    entry_t mq [$];
    logic [31:0] got [$];

    inst_queue_if q_if ();

    inst_queue #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .flush    (flush),
        .ROB_full (rob),
        .RS_full  (rs),
        .LSB_full (lsb),
        .iq       (q_if.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [70:0] act, input logic [70:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic entry_t dut_out();
        return '{inst: q_if.ifetch_inst, pc: q_if.ifetch_pc, optype: q_if.ifetch_optype, pred_jump: q_if.ifetch_pred_jump};
    endfunction

    // Reference model: outputs follow from queue contents and this cycle's inputs; state updates for the next edge.
    always @(negedge clk) begin
        if (chk_en) begin
            entry_t in_e, exp_e;
            logic   exp_ready, exp_valid, byp;
            in_e = '{inst: q_if.in_inst, pc: q_if.in_pc, optype: q_if.in_optype, pred_jump: q_if.in_pred_jump};
            exp_ready = mq.size() != DEPTH;
            byp = BYP && mq.size() == 0 && q_if.in_valid && unit_free(in_e.optype, rob, rs, lsb);
            exp_valid = rdy && !rst && !flush && (mq.size() != 0 ? unit_free(mq[0].optype, rob, rs, lsb) : byp);
            exp_e = !exp_valid ? '0 : (mq.size() != 0 ? mq[0] : in_e);
            chk("in_ready", 71'(q_if.in_ready), 71'(exp_ready));
            chk("ifetch_valid", 71'(q_if.ifetch_valid), 71'(exp_valid));
            chk("ifetch_data", dut_out(), exp_e);
            if (rst || flush) mq.delete();
            else if (rdy) begin
                if (exp_valid && mq.size() != 0) void'(mq.pop_front());
                if (q_if.in_valid && exp_ready && !(exp_valid && byp)) mq.push_back(in_e);
            end
        end
    end

    task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] pc);
        q_if.in_valid = v;
        q_if.in_optype = op;
        q_if.in_pc = pc;
        q_if.in_inst = $urandom;
        q_if.in_pred_jump = 1'($urandom);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [5:0] rand_op();
        case ($urandom_range(4))
            0: return OP_LB - 6'd1;
            1: return OP_LB;
            2: return OP_SW;
            3: return OP_SW + 6'd1;
            default: return 6'($urandom);
        endcase
    endfunction

    initial begin
        int k;
        drive(1'b0, OP_ADD, 32'h0);
        step();
        step();
        rst = 1'b0;
        chk_en = 1'b1;
        sample();
        chk("reset_ready", 71'(q_if.in_ready), 71'(1));
        chk("reset_valid", 71'(q_if.ifetch_valid), 71'(0));
        chk("reset_pc", 71'(q_if.ifetch_pc), 71'(0));

        step();
        drive(1'b1, OP_ADD, 32'h100);
        if (BYP) begin
            sample();
            chk("bypass_valid", 71'(q_if.ifetch_valid), 71'(1));
            chk("bypass_pc", 71'(q_if.ifetch_pc), 71'(32'h100));
        end
        step();
        drive(1'b0, OP_ADD, 32'h0);
        sample();
        chk("single_valid", 71'(q_if.ifetch_valid), 71'(!BYP));
        chk("single_pc", 71'(q_if.ifetch_pc), BYP ? 71'(0) : 71'(32'h100));
        step();
        sample();
        chk("single_drained", 71'(q_if.ifetch_valid), 71'(0));

        step();
        lsb = 1'b1;
        drive(1'b1, OP_LW, 32'h200);
        step();
        drive(1'b1, OP_ADD, 32'h204);
        step();
        drive(1'b0, OP_ADD, 32'h0);
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("ls_blocked", 71'(q_if.ifetch_valid), 71'(0));
            step();
        end
        lsb = 1'b0;
        sample();
        chk("ls_issue_pc", 71'(q_if.ifetch_pc), 71'(32'h200));
        step();
        sample();
        chk("add_issue_pc", 71'(q_if.ifetch_pc), 71'(32'h204));
        step();

        rob = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, OP_ADD, 32'h300 + 32'(4 * i));
            step();
        end
        drive(1'b1, OP_ADD, 32'h3fc);
        sample();
        chk("full_ready", 71'(q_if.in_ready), 71'(0));
        step();
        rob = 1'b0;
        k = 8;
        for (int c = 0; c < 60 && got.size() < 16; c++) begin
            if (k < 16 && q_if.in_ready) begin
                drive(1'b1, OP_ADD, 32'h300 + 32'(4 * k));
                k++;
            end else drive(1'b0, OP_ADD, 32'h0);
            sample();
            if (q_if.ifetch_valid) got.push_back(q_if.ifetch_pc);
            step();
        end
        drive(1'b0, OP_ADD, 32'h0);
        chk("wrap_count", 71'(got.size()), 71'(16));
        for (int i = 0; i < got.size(); i++) chk("wrap_pc", 71'(got[i]), 71'(32'h300 + 32'(4 * i)));

        rob = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, OP_ADD, 32'h400 + 32'(4 * i));
            step();
        end
        flush = 1'b1;
        rob = 1'b0;
        drive(1'b1, OP_ADD, 32'hbad);
        sample();
        chk("flush_valid", 71'(q_if.ifetch_valid), 71'(0));
        step();
        flush = 1'b0;
        drive(1'b0, OP_ADD, 32'h0);
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("flush_empty", 71'(q_if.ifetch_valid), 71'(0));
            step();
        end

        rob = 1'b1;
        drive(1'b1, OP_ADD, 32'h500);
        step();
        drive(1'b1, OP_ADD, 32'h504);
        step();
        drive(1'b0, OP_ADD, 32'h0);
        rdy = 1'b0;
        rob = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("rdy_low_valid", 71'(q_if.ifetch_valid), 71'(0));
            step();
        end
        rdy = 1'b1;
        sample();
        chk("rdy_resume_pc", 71'(q_if.ifetch_pc), 71'(32'h500));
        step();
        sample();
        chk("rdy_second_pc", 71'(q_if.ifetch_pc), 71'(32'h504));
        step();

        for (int c = 0; c < 3000; c++) begin
            rst = $urandom_range(199) == 0;
            flush = $urandom_range(49) == 0;
            rdy = $urandom_range(9) != 0;
            rob = $urandom_range(3) == 0;
            rs = $urandom_range(2) == 0;
            lsb = $urandom_range(2) == 0;
            drive(1'($urandom_range(1)), rand_op(), $urandom);
            step();
        end
        rst = 1'b0;
        flush = 1'b0;
        rdy = 1'b1;
        drive(1'b0, OP_ADD, 32'h0);
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
